// File: rtl/my_alu_seq_if.sv
// Valid/ready bundle between a producer/consumer pair and the sequential ALU.
// master: the side that issues operations and consumes results.
// slave: the arithmetic unit.
interface my_alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/my_alu_seq.sv
// Sequential unsigned arithmetic unit: add, sub, mul, div, rem.
// Add/sub, illegal ops and divide-by-zero resolve at the accept edge.
// Mul (shift-add) and div/rem (restoring) iterate for WIDTH cycles.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for an operation; in_ready high
//  CALC  | iterative mul/div/rem in progress; cnt_q counts down to 0
//  DONE  | result/err held with out_valid high until out_ready
module my_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    my_alu_seq_if.slave   bus
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           op_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;

    // multiplier datapath: product accumulator, shifting multiplicand, shifting multiplier
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    // divider datapath: partial remainder, dividend shifting into quotient, divisor
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     dvsr_q;

    logic                 fast_path;
    logic [2*WIDTH-1:0]   fast_res;
    logic                 fast_err;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;

    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_fits;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;

    // Ops that resolve at the accept edge, computed straight from the bus
    always_comb begin
        fast_path = 1'b1;
        fast_res  = '0;
        fast_err  = 1'b0;
        sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w    = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.op)
            OP_ADD: fast_res = {{(WIDTH-1){1'b0}}, sum_w};
            // bit WIDTH of the extended difference is the borrow, i.e. the sign
            OP_SUB: fast_res = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
            OP_MUL: fast_path = 1'b0;
            OP_DIV: begin
                if (bus.b == '0) begin
                    fast_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    fast_err = 1'b1;
                end else begin
                    fast_path = 1'b0;
                end
            end
            OP_REM: begin
                if (bus.b == '0) begin
                    fast_res = {{WIDTH{1'b0}}, bus.a};
                    fast_err = 1'b1;
                end else begin
                    fast_path = 1'b0;
                end
            end
            default: fast_err = 1'b1;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide
    always_comb begin
        prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvsr_q};
        div_fits  = (div_shift >= {1'b0, dvsr_q});
        // partial remainder stays below the divisor, so WIDTH bits always suffice
        rem_d     = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], div_fits};
    end

    // Control FSM and datapath registers; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        in_ready_q <= 1'b0;
                        if (fast_path) begin
                            result_q    <= fast_res;
                            err_q       <= fast_err;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q    <= CW'(WIDTH - 1);
                            prod_q   <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                            mplier_q <= bus.b;
                            rem_q    <= '0;
                            quo_q    <= bus.a;
                            dvsr_q   <= bus.b;
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q == OP_MUL) begin
                        prod_q   <= prod_d;
                        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                    end
                    if (cnt_q == '0) begin
                        // last step: publish the step's outcome directly
                        if (op_q == OP_MUL) begin
                            result_q <= prod_d;
                        end else if (op_q == OP_DIV) begin
                            result_q <= {{WIDTH{1'b0}}, quo_d};
                        end else begin
                            result_q <= {{WIDTH{1'b0}}, rem_d};
                        end
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_my_alu_seq.sv
// Directed bench for my_alu_seq at WIDTH=8.
module tb_my_alu_seq;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    my_alu_seq_if #(.WIDTH(W)) bus ();

    my_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one op for one edge; returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency counted as 1 when out_valid is already up #1 after the accept edge.
    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] res, output logic e, output int lat);
        bit rdy;
        send(op, a, b);
        wait_out(lat, rdy);
        res = bus.result;
        e   = bus.err;
        consume();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 16'h0000) $display("FAIL reset_result got %h want 0000", bus.result);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int lat;
        bit rdy;
        send(3'd0, 8'd90, 8'd102);
        wait_out(lat, rdy);
        total_cnt++;
        if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== 16'd192 || bus.err !== 1'b0)
            $display("FAIL add_90_102 got %0d err %b want 192 err 0", bus.result, bus.err);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL add_in_ready_done got %b want 0", bus.in_ready);
        else pass_cnt++;
        consume();
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL add_handshake got in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        logic [2*W-1:0] r;
        logic e;
        int lat;
        run_op(3'd1, 8'd90, 8'd75, r, e, lat);
        total_cnt++;
        if (r !== 16'd15 || e !== 1'b0 || lat !== 1)
            $display("FAIL sub_90_75 got %h err %b lat %0d want 000f 0 1", r, e, lat);
        else pass_cnt++;
        run_op(3'd1, 8'd75, 8'd90, r, e, lat);
        total_cnt++;
        if (r !== 16'hFFF1 || e !== 1'b0)
            $display("FAIL sub_75_90 got %h err %b want fff1 0", r, e);
        else pass_cnt++;
        run_op(3'd1, 8'd0, 8'd255, r, e, lat);
        total_cnt++;
        if (r !== 16'hFF01) $display("FAIL sub_0_255 got %h want ff01", r);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat;
        bit rdy;
        logic [2*W-1:0] r;
        logic e;
        run_op(3'd2, 8'd2, 8'd75, r, e, lat);
        total_cnt++;
        if (r !== 16'd150 || e !== 1'b0 || lat !== 9)
            $display("FAIL mul_2_75 got %0d err %b lat %0d want 150 0 9", r, e, lat);
        else pass_cnt++;
        send(3'd2, 8'd255, 8'd255);
        wait_out(lat, rdy);
        total_cnt++;
        if (bus.result !== 16'd65025 || lat !== 9)
            $display("FAIL mul_255_255 got %0d lat %0d want 65025 9", bus.result, lat);
        else pass_cnt++;
        total_cnt++;
        if (rdy !== 1'b0) $display("FAIL mul_in_ready_calc got %b want 0", rdy);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_div();
        logic [2*W-1:0] r;
        logic e;
        int lat;
        run_op(3'd3, 8'd102, 8'd2, r, e, lat);
        total_cnt++;
        if (r !== 16'd51 || e !== 1'b0 || lat !== 9)
            $display("FAIL div_102_2 got %0d err %b lat %0d want 51 0 9", r, e, lat);
        else pass_cnt++;
        run_op(3'd4, 8'd102, 8'd75, r, e, lat);
        total_cnt++;
        if (r !== 16'd27 || e !== 1'b0 || lat !== 9)
            $display("FAIL rem_102_75 got %0d err %b lat %0d want 27 0 9", r, e, lat);
        else pass_cnt++;
        run_op(3'd3, 8'd255, 8'd7, r, e, lat);
        total_cnt++;
        if (r !== 16'd36) $display("FAIL div_255_7 got %0d want 36", r);
        else pass_cnt++;
        run_op(3'd3, 8'd102, 8'd0, r, e, lat);
        total_cnt++;
        if (r !== 16'h00FF || e !== 1'b1 || lat !== 1)
            $display("FAIL div_by_zero got %h err %b lat %0d want 00ff 1 1", r, e, lat);
        else pass_cnt++;
        run_op(3'd4, 8'd102, 8'd0, r, e, lat);
        total_cnt++;
        if (r !== 16'd102 || e !== 1'b1 || lat !== 1)
            $display("FAIL rem_by_zero got %0d err %b lat %0d want 102 1 1", r, e, lat);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [2*W-1:0] r;
        logic e;
        int lat;
        run_op(3'd6, 8'd12, 8'd34, r, e, lat);
        total_cnt++;
        if (r !== 16'd0 || e !== 1'b1 || lat !== 1)
            $display("FAIL illegal_op6 got %0d err %b lat %0d want 0 1 1", r, e, lat);
        else pass_cnt++;
        run_op(3'd0, 8'd3, 8'd4, r, e, lat);
        total_cnt++;
        if (r !== 16'd7 || e !== 1'b0)
            $display("FAIL err_clears got %0d err %b want 7 0", r, e);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lat;
        bit rdy;
        bit stable = 1'b1;
        send(3'd2, 8'd13, 8'd11);
        wait_out(lat, rdy);
        for (int i = 0; i < 5; i++) begin
            bus.op = 3'd0;
            bus.a = 8'd1;
            bus.b = 8'd1;
            bus.in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.result !== 16'd143 || bus.err !== 1'b0) stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (stable !== 1'b1 || bus.result !== 16'd143)
            $display("FAIL bp_stable got %0d want 143 held", bus.result);
        else pass_cnt++;
        consume();
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release got in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_no_ghost got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] r;
        logic e;
        int lat;
        bit seen = 1'b0;
        send(3'd2, 8'd200, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_mid_async got out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_mid_stale got stale %b in_ready %b want 0 1", seen, bus.in_ready);
        else pass_cnt++;
        run_op(3'd0, 8'd1, 8'd1, r, e, lat);
        total_cnt++;
        if (r !== 16'd2 || e !== 1'b0 || lat !== 1)
            $display("FAIL rst_mid_add got %0d err %b lat %0d want 2 0 1", r, e, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] r;
        logic e;
        int lat;
        run_op(3'd0, 8'd200, 8'd100, r, e, lat);
        total_cnt++;
        if (r !== 16'h012C) $display("FAIL b2b_add_carry got %h want 012c", r);
        else pass_cnt++;
        run_op(3'd0, 8'd255, 8'd255, r, e, lat);
        total_cnt++;
        if (r !== 16'h01FE || lat !== 1) $display("FAIL b2b_add_max got %h lat %0d want 01fe 1", r, lat);
        else pass_cnt++;
        run_op(3'd4, 8'd200, 8'd7, r, e, lat);
        total_cnt++;
        if (r !== 16'd4 || e !== 1'b0) $display("FAIL b2b_rem got %0d err %b want 4 0", r, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
